// File: rtl/vga_sync_monitor.sv
// VGA receive-side timing monitor: recovers pixel X/Y, measures line/frame periods, tracks lock.
// Pixel capture has 1-clock latency. H_MEAS/V_MEAS/SYNC_ERR/FRAME_START/LOCKED update the cycle after the edge.
// There is no backpressure: every clock is consumed.
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLOCK_25,
    input  logic        RESET,
    input  logic        VGA_HSYNC,
    input  logic        VGA_VSYNC,
    input  logic        VGA_BLANK,
    input  logic [9:0]  VGA_R,
    input  logic [9:0]  VGA_G,
    input  logic [9:0]  VGA_B,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic [29:0] RGB,
    output logic        PIXEL_VALID,
    output logic [10:0] H_MEAS,
    output logic [9:0]  V_MEAS,
    output logic        LOCKED,
    output logic        FRAME_START,
    output logic        SYNC_ERR
);

    localparam logic [9:0]  H_ACT_L  = 10'(H_ACTIVE);
    localparam logic [10:0] H_TOT_L  = 11'(H_TOTAL);
    localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
    localparam logic [9:0]  V_TOT_L  = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_L   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  good, good_nxt;
    logic        frame_bad, frame_bad_nxt;
    logic        err_nxt;

    logic        hs_prev, vs_prev;
    logic [10:0] h_cnt;
    logic [9:0]  line_cnt;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic        h_valid;

    logic        hs_fall, vs_fall;
    logic        h_tmo, v_tmo, tmo;
    logic [10:0] line_period;
    logic        line_end_active;
    logic        line_viol, frame_viol;
    logic [9:0]  frame_lines;
    logic [10:0] active_lines;
    logic [3:0]  good_inc;

    assign hs_fall = hs_prev & ~VGA_HSYNC;
    assign vs_fall = vs_prev & ~VGA_VSYNC;

    assign h_tmo = (h_cnt == 11'h7FF);
    assign v_tmo = (line_cnt == 10'h3FF);
    assign tmo   = h_tmo | v_tmo;

    // Saturated counters report the ceiling rather than wrapping to a small, plausible-looking period.
    assign line_period = h_tmo ? 11'h7FF : h_cnt + 11'd1;
    assign frame_lines = v_tmo ? 10'h3FF : line_cnt + {9'd0, hs_fall};

    assign line_end_active = hs_fall & (x_cnt != 10'd0);
    assign active_lines    = {1'b0, y_cnt} + {10'd0, line_end_active};

    assign line_viol  = hs_fall & h_valid &
                        ((line_period != H_TOT_L) | ((x_cnt != 10'd0) & (x_cnt != H_ACT_L)));
    assign frame_viol = vs_fall & ((frame_lines != V_TOT_L) | (active_lines != V_ACT_L));

    assign good_inc = good + 4'd1;

    always_comb begin
        state_nxt     = state;
        good_nxt      = good;
        frame_bad_nxt = frame_bad;
        err_nxt       = 1'b0;
        case (state)
            S_SEARCH: begin
                if (!tmo && vs_fall) begin
                    state_nxt     = S_ACQUIRE;
                    good_nxt      = 4'd0;
                    frame_bad_nxt = 1'b0;
                end
            end
            S_ACQUIRE: begin
                if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_SEARCH;
                end else if (vs_fall) begin
                    // A line ending on this same edge belongs to the frame being judged.
                    err_nxt       = line_viol | frame_viol;
                    frame_bad_nxt = 1'b0;
                    if (frame_bad | line_viol | frame_viol) begin
                        good_nxt = 4'd0;
                    end else begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_L) begin
                            state_nxt = S_LOCKED;
                        end
                    end
                end else if (line_viol) begin
                    err_nxt       = 1'b1;
                    frame_bad_nxt = 1'b1;
                end
            end
            S_LOCKED: begin
                if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_SEARCH;
                end else if (line_viol | frame_viol) begin
                    err_nxt       = 1'b1;
                    state_nxt     = S_ACQUIRE;
                    good_nxt      = 4'd0;
                    // A mid-frame line fault taints the frame still in progress.
                    frame_bad_nxt = ~vs_fall;
                end
            end
            default: begin
                state_nxt = S_SEARCH;
            end
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (RESET) begin
            state       <= S_SEARCH;
            good        <= 4'd0;
            frame_bad   <= 1'b0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            h_cnt       <= 11'd0;
            line_cnt    <= 10'd0;
            x_cnt       <= 10'd0;
            y_cnt       <= 10'd0;
            h_valid     <= 1'b0;
            X           <= 10'd0;
            Y           <= 10'd0;
            RGB         <= 30'd0;
            PIXEL_VALID <= 1'b0;
            H_MEAS      <= 11'd0;
            V_MEAS      <= 10'd0;
            FRAME_START <= 1'b0;
            SYNC_ERR    <= 1'b0;
        end else begin
            state     <= state_nxt;
            good      <= good_nxt;
            frame_bad <= frame_bad_nxt;
            hs_prev   <= VGA_HSYNC;
            vs_prev   <= VGA_VSYNC;

            if (hs_fall) begin
                H_MEAS <= line_period;
                h_cnt  <= 11'd0;
            end else if (!h_tmo) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (tmo) begin
                h_valid <= 1'b0;
            end else if (hs_fall) begin
                h_valid <= 1'b1;
            end

            if (hs_fall) begin
                x_cnt <= 10'd0;
            end else if (VGA_BLANK && (x_cnt != 10'h3FF)) begin
                x_cnt <= x_cnt + 10'd1;
            end

            if (vs_fall) begin
                y_cnt <= 10'd0;
            end else if (line_end_active) begin
                y_cnt <= y_cnt + 10'd1;
            end

            if (vs_fall) begin
                V_MEAS   <= frame_lines;
                line_cnt <= 10'd0;
            end else if (hs_fall && !v_tmo) begin
                line_cnt <= line_cnt + 10'd1;
            end

            PIXEL_VALID <= VGA_BLANK;
            if (VGA_BLANK) begin
                X   <= x_cnt;
                Y   <= y_cnt;
                RGB <= {VGA_R, VGA_G, VGA_B};
            end

            FRAME_START <= vs_fall;
            SYNC_ERR    <= err_nxt;
        end
    end

    assign LOCKED = (state == S_LOCKED);

endmodule
